// File: rtl/memp_vector_streamer.sv
// memp_vector_streamer
//   Read-side sequencer for a memP-style wide vector memory. A start command
//   walks a contiguous range of word addresses on read_address_o. Each word
//   returned by the combinational read port is captured into out_data_o and
//   offered on a valid/ready stream. finish_o pulses for one cycle once the
//   last word has been taken.
//
// Ports
//   clk_i            clock, everything on the rising edge
//   reset_i          synchronous active-high reset
//   start_i          command strobe, only looked at while idle
//   base_address_i   first word address of the command
//   word_count_i     number of words in the command (0 = empty command)
//   read_address_o   registered address driven to the memory read port
//   memory_output_i  combinational read data for read_address_o
//   out_data_o       registered stream word
//   out_valid_o      out_data_o holds a word
//   out_ready_i      downstream takes the word this cycle
//   busy_o           a command is in progress
//   finish_o         one-cycle completion pulse
//   out_last_o       (MEMP_STREAM_LAST_EN only) current word is the final one
//
// Build option
//   MEMP_STREAM_LAST_EN : adds the out_last_o flag. Undefined by default.

module memp_vector_streamer #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int address_width = 20
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 start_i,
  input  logic [address_width-1:0]             base_address_i,
  input  logic [address_width-1:0]             word_count_i,
  output logic [address_width-1:0]             read_address_o,
  input  logic [no_of_units*element_width-1:0] memory_output_i,
  output logic [no_of_units*element_width-1:0] out_data_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 busy_o,
  output logic                                 finish_o
`ifdef MEMP_STREAM_LAST_EN
  ,
  output logic                                 out_last_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t                               state_q;
  logic [address_width-1:0]             read_address_q;
  logic [address_width-1:0]             read_address_d;
  logic [address_width-1:0]             remaining_q;
  logic [address_width-1:0]             remaining_d;
  logic [no_of_units*element_width-1:0] out_data_q;
  logic                                 out_valid_q;
  logic                                 busy_q;
  logic                                 finish_q;
  logic                                 slot_free;
  logic                                 load;
`ifdef MEMP_STREAM_LAST_EN
  logic                                 out_last_q;
`endif

  // The output register can take a new word when it is empty or when its
  // current word is being accepted in this same cycle.
  always_comb begin
    slot_free      = !out_valid_q || out_ready_i;
    load           = (state_q == STREAM) && (remaining_q != '0) && slot_free;
    read_address_d = read_address_q + address_width'(1);
    remaining_d    = remaining_q - address_width'(1);
  end

  // Single-process FSM; every output comes straight from a register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      read_address_q <= '0;
      remaining_q    <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      finish_q       <= 1'b0;
`ifdef MEMP_STREAM_LAST_EN
      out_last_q     <= 1'b0;
`endif
    end else begin
      finish_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (word_count_i != '0) begin
              read_address_q <= base_address_i;
              remaining_q    <= word_count_i;
              busy_q         <= 1'b1;
              state_q        <= STREAM;
            end else begin
              // Empty command: report completion without ever going busy.
              finish_q <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        STREAM: begin
          if (load) begin
            // Word is sampled now, so later writes to this address are not seen.
            out_data_q     <= memory_output_i;
            out_valid_q    <= 1'b1;
            read_address_q <= read_address_d;
            remaining_q    <= remaining_d;
`ifdef MEMP_STREAM_LAST_EN
            out_last_q     <= (remaining_q == address_width'(1));
`endif
          end else if ((remaining_q == '0) && slot_free) begin
            // Final word has left (or is leaving) the output register.
            out_valid_q <= 1'b0;
            finish_q    <= 1'b1;
            state_q     <= DONE;
`ifdef MEMP_STREAM_LAST_EN
            out_last_q  <= 1'b0;
`endif
          end else if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
`ifdef MEMP_STREAM_LAST_EN
            out_last_q  <= 1'b0;
`endif
          end
        end
        DONE: begin
          // finish and busy drop together on this edge; start is ignored here.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_address_o = read_address_q;
  assign out_data_o     = out_data_q;
  assign out_valid_o    = out_valid_q;
  assign busy_o         = busy_q;
  assign finish_o       = finish_q;
`ifdef MEMP_STREAM_LAST_EN
  assign out_last_o     = out_last_q;
`endif

endmodule

// File: tb/tb_memp_vector_streamer.sv
// tb_memp_vector_streamer
//   Self-checking bench for memp_vector_streamer. A 64-entry memory aliased on
//   the low address bits feeds the read port. Expected word sequences come
//   from the command (base, count) and the memory contents alone.
//   Honours MEMP_STREAM_LAST_EN to connect and check out_last.

module tb_memp_vector_streamer;

  localparam int EW = 32;
  localparam int NU = 8;
  localparam int AW = 20;
  localparam int WW = EW * NU;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW-1:0] word_count;
  logic [AW-1:0] read_address;
  logic [WW-1:0] memory_output;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          finish;
`ifdef MEMP_STREAM_LAST_EN
  logic          out_last;
`endif

  logic [WW-1:0] mem [64];

  int assertions;
  int failures;

  // Observations collected by run_command
  logic [WW-1:0] obsWords[$];
  logic          obsLast[$];
  logic [AW-1:0] obsAddr[$];
  int            obsFinishCycle;
  int            obsFirstValid;
  int            obsStableErr;
  logic          obsTimeout;
  logic          obsBusyAtStart;
  logic          obsBusyAtFinish;
  logic          obsValidAtFinish;
  logic          obsFinishAfter;
  logic          obsBusyAfter;
  logic          obsFinishLater;
  logic          obsBusyLater;

  // Expected stream built from the command and memory contents
  logic [WW-1:0] expWords[$];
  logic          expLast[$];

  assign memory_output = mem[read_address[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  memp_vector_streamer #(
    .element_width(EW),
    .no_of_units  (NU),
    .address_width(AW)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .start_i        (start),
    .base_address_i (base_address),
    .word_count_i   (word_count),
    .read_address_o (read_address),
    .memory_output_i(memory_output),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .busy_o         (busy),
    .finish_o       (finish)
`ifdef MEMP_STREAM_LAST_EN
    ,
    .out_last_o     (out_last)
`endif
  );

  // Fill every memory word with fresh random elements.
  task automatic fill_memory();
    for (int i = 0; i < 64; i++)
      for (int u = 0; u < NU; u++)
        mem[i][u*EW +: EW] = $urandom;
  endtask

  // Expected words: consecutive addresses from base, wrapping at 2^AW.
  task automatic build_expected(input logic [AW-1:0] base, input logic [AW-1:0] count);
    logic [AW-1:0] a;
    expWords.delete();
    expLast.delete();
    for (int i = 0; i < int'(count); i++) begin
      a = base + AW'(i);
      expWords.push_back(mem[a[5:0]]);
      expLast.push_back(i == int'(count) - 1);
    end
  endtask

  // Drive one command and record what the DUT does until finish (bounded).
  // readyMode: 0 always ready, 1 alternating 1/0, 2 random.
  task automatic run_command(input logic [AW-1:0] base, input logic [AW-1:0] count,
                             input int readyMode, input int restartAt, input bit startOnFinish);
    logic          prevValid;
    logic          prevReady;
    logic          prevLast;
    logic          curLast;
    logic [WW-1:0] prevData;
    obsWords.delete();
    obsLast.delete();
    obsAddr.delete();
    obsFinishCycle   = -1;
    obsFirstValid    = -1;
    obsStableErr     = 0;
    obsTimeout       = 1'b1;
    obsBusyAtStart   = 1'b0;
    obsBusyAtFinish  = 1'b0;
    obsValidAtFinish = 1'b0;
    prevValid = 1'b0;
    prevReady = 1'b0;
    prevLast  = 1'b0;
    prevData  = '0;
    @(negedge clk);
    start        = 1'b1;
    base_address = base;
    word_count   = count;
    out_ready    = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      curLast = 1'b0;
`ifdef MEMP_STREAM_LAST_EN
      curLast = out_last;
`endif
      start        = (cyc == restartAt);
      base_address = AW'($urandom);
      word_count   = AW'($urandom_range(1, 6));
      if (prevValid && !prevReady &&
          (!out_valid || out_data !== prevData || curLast !== prevLast))
        obsStableErr++;
      obsAddr.push_back(read_address);
      if (cyc == 0) obsBusyAtStart = busy;
      if (out_valid && obsFirstValid < 0) obsFirstValid = cyc;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        obsWords.push_back(out_data);
        obsLast.push_back(curLast);
      end
      prevValid = out_valid;
      prevReady = out_ready;
      prevData  = out_data;
      prevLast  = curLast;
      if (finish) begin
        obsFinishCycle   = cyc;
        obsBusyAtFinish  = busy;
        obsValidAtFinish = out_valid;
        obsTimeout       = 1'b0;
        if (startOnFinish) begin
          start      = 1'b1;
          word_count = AW'(3);
        end
        break;
      end
    end
    @(negedge clk);
    obsFinishAfter = finish;
    obsBusyAfter   = busy;
    start          = 1'b0;
    out_ready      = 1'b1;
    @(negedge clk);
    obsFinishLater = finish;
    obsBusyLater   = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    assertions++; if (read_address !== '0) begin failures++; $display("[TB] FAIL reset_read_address: got %h expected 0", read_address); end
    assertions++; if (out_data !== '0) begin failures++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    assertions++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    assertions++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    assertions++; if (finish !== 1'b0) begin failures++; $display("[TB] FAIL reset_finish: got %b expected 0", finish); end
`ifdef MEMP_STREAM_LAST_EN
    assertions++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_stream();
    fill_memory();
    build_expected(AW'(5), AW'(3));
    run_command(AW'(5), AW'(3), 0, -1, 1'b0);
    assertions++; if (obsTimeout !== 1'b0) begin failures++; $display("[TB] FAIL basic_timeout: got %b expected 0", obsTimeout); end
    assertions++; if (obsWords.size() !== 3) begin failures++; $display("[TB] FAIL basic_word_count: got %0d expected 3", obsWords.size()); end
    for (int i = 0; i < obsWords.size() && i < 3; i++) begin
      assertions++; if (obsWords[i] !== expWords[i]) begin failures++; $display("[TB] FAIL basic_word%0d: got %h expected %h", i, obsWords[i], expWords[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      assertions++; if (obsAddr.size() <= i || obsAddr[i] !== AW'(5 + i)) begin failures++; $display("[TB] FAIL basic_read_address%0d: got %h expected %h", i, (obsAddr.size() > i) ? obsAddr[i] : AW'(0), AW'(5 + i)); end
    end
    assertions++; if (obsBusyAtStart !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_rise: got %b expected 1", obsBusyAtStart); end
    assertions++; if (obsFirstValid !== 1) begin failures++; $display("[TB] FAIL basic_first_valid_cycle: got %0d expected 1", obsFirstValid); end
    assertions++; if (obsFinishCycle !== 4) begin failures++; $display("[TB] FAIL basic_finish_cycle: got %0d expected 4", obsFinishCycle); end
    assertions++; if (obsBusyAtFinish !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_at_finish: got %b expected 1", obsBusyAtFinish); end
    assertions++; if (obsValidAtFinish !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_at_finish: got %b expected 0", obsValidAtFinish); end
    assertions++; if (obsFinishAfter !== 1'b0) begin failures++; $display("[TB] FAIL basic_finish_width: got %b expected 0", obsFinishAfter); end
    assertions++; if (obsBusyAfter !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_fall: got %b expected 0", obsBusyAfter); end
  endtask

  task automatic test_backpressure();
    fill_memory();
    build_expected(AW'(0), AW'(4));
    run_command(AW'(0), AW'(4), 1, -1, 1'b0);
    assertions++; if (obsTimeout !== 1'b0) begin failures++; $display("[TB] FAIL bp_timeout: got %b expected 0", obsTimeout); end
    assertions++; if (obsWords.size() !== 4) begin failures++; $display("[TB] FAIL bp_word_count: got %0d expected 4", obsWords.size()); end
    for (int i = 0; i < obsWords.size() && i < 4; i++) begin
      assertions++; if (obsWords[i] !== expWords[i]) begin failures++; $display("[TB] FAIL bp_word%0d: got %h expected %h", i, obsWords[i], expWords[i]); end
    end
    assertions++; if (obsStableErr !== 0) begin failures++; $display("[TB] FAIL bp_hold_stable: got %0d unstable cycles expected 0", obsStableErr); end
    assertions++; if (obsBusyAfter !== 1'b0) begin failures++; $display("[TB] FAIL bp_busy_fall: got %b expected 0", obsBusyAfter); end
  endtask

  task automatic test_zero_count();
    run_command(AW'($urandom), AW'(0), 0, -1, 1'b1);
    assertions++; if (obsTimeout !== 1'b0) begin failures++; $display("[TB] FAIL zero_timeout: got %b expected 0", obsTimeout); end
    assertions++; if (obsFirstValid !== -1) begin failures++; $display("[TB] FAIL zero_no_valid: got first valid at %0d expected none", obsFirstValid); end
    assertions++; if (obsFinishCycle !== 0) begin failures++; $display("[TB] FAIL zero_finish_cycle: got %0d expected 0", obsFinishCycle); end
    assertions++; if (obsBusyAtFinish !== 1'b0) begin failures++; $display("[TB] FAIL zero_busy: got %b expected 0", obsBusyAtFinish); end
    assertions++; if (obsBusyAfter !== 1'b0) begin failures++; $display("[TB] FAIL zero_start_in_done_busy: got %b expected 0", obsBusyAfter); end
    assertions++; if (obsFinishAfter !== 1'b0) begin failures++; $display("[TB] FAIL zero_finish_width: got %b expected 0", obsFinishAfter); end
    assertions++; if (obsBusyLater !== 1'b0 || obsFinishLater !== 1'b0) begin failures++; $display("[TB] FAIL zero_start_in_done_ignored: got busy=%b finish=%b expected 0 0", obsBusyLater, obsFinishLater); end
  endtask

  task automatic test_wrap();
    fill_memory();
    build_expected(AW'('hFFFFE), AW'(4));
    run_command(AW'('hFFFFE), AW'(4), 0, -1, 1'b0);
    assertions++; if (obsWords.size() !== 4) begin failures++; $display("[TB] FAIL wrap_word_count: got %0d expected 4", obsWords.size()); end
    for (int i = 0; i < obsWords.size() && i < 4; i++) begin
      assertions++; if (obsWords[i] !== expWords[i]) begin failures++; $display("[TB] FAIL wrap_word%0d: got %h expected %h", i, obsWords[i], expWords[i]); end
    end
    assertions++; if (obsAddr.size() < 5 || obsAddr[4] !== AW'('h00002)) begin failures++; $display("[TB] FAIL wrap_final_address: got %h expected 00002", (obsAddr.size() > 4) ? obsAddr[4] : AW'(0)); end
  endtask

  task automatic test_reset_mid_stream();
    int taken;
    int finishes;
    bit reached;
    fill_memory();
    taken   = 0;
    reached = 1'b0;
    @(negedge clk);
    start        = 1'b1;
    base_address = AW'(3);
    word_count   = AW'(5);
    out_ready    = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ready) taken++;
      if (taken == 2) begin
        reached = 1'b1;
        reset   = 1'b1;
        break;
      end
    end
    assertions++; if (reached !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_two_words: got %0d words expected 2", taken); end
    @(negedge clk);
    reset = 1'b0;
    assertions++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    assertions++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    assertions++; if (finish !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_finish: got %b expected 0", finish); end
    assertions++; if (read_address !== '0) begin failures++; $display("[TB] FAIL rstmid_read_address: got %h expected 0", read_address); end
    finishes = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (finish || out_valid) finishes++;
    end
    assertions++; if (finishes !== 0) begin failures++; $display("[TB] FAIL rstmid_abandoned: got %0d active cycles expected 0", finishes); end
    build_expected(AW'(10), AW'(1));
    run_command(AW'(10), AW'(1), 0, -1, 1'b0);
    assertions++; if (obsWords.size() !== 1 || obsWords[0] !== expWords[0]) begin failures++; $display("[TB] FAIL rstmid_restream: got %0d words, first %h expected 1 word %h", obsWords.size(), (obsWords.size() > 0) ? obsWords[0] : '0, expWords[0]); end
    assertions++; if (obsFinishCycle !== 2) begin failures++; $display("[TB] FAIL rstmid_restream_finish: got %0d expected 2", obsFinishCycle); end
  endtask

  task automatic test_restart_ignored();
    logic [AW-1:0] base;
    fill_memory();
    base = AW'($urandom);
    build_expected(base, AW'(3));
    run_command(base, AW'(3), 0, 1, 1'b0);
    assertions++; if (obsWords.size() !== 3) begin failures++; $display("[TB] FAIL restart_word_count: got %0d expected 3", obsWords.size()); end
    for (int i = 0; i < obsWords.size() && i < 3; i++) begin
      assertions++; if (obsWords[i] !== expWords[i]) begin failures++; $display("[TB] FAIL restart_word%0d: got %h expected %h", i, obsWords[i], expWords[i]); end
`ifdef MEMP_STREAM_LAST_EN
      assertions++; if (obsLast[i] !== expLast[i]) begin failures++; $display("[TB] FAIL restart_last%0d: got %b expected %b", i, obsLast[i], expLast[i]); end
`endif
    end
    assertions++; if (obsFinishCycle !== 4) begin failures++; $display("[TB] FAIL restart_finish_cycle: got %0d expected 4", obsFinishCycle); end
    assertions++; if (obsBusyLater !== 1'b0) begin failures++; $display("[TB] FAIL restart_idle_after: got busy %b expected 0", obsBusyLater); end
  endtask

  task automatic test_random_commands();
    logic [AW-1:0] base;
    logic [AW-1:0] count;
    for (int it = 0; it < 8; it++) begin
      fill_memory();
      base  = AW'($urandom);
      count = AW'($urandom_range(1, 8));
      build_expected(base, count);
      run_command(base, count, 2, int'($urandom_range(0, 4)), 1'b0);
      assertions++; if (obsTimeout !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_timeout: got %b expected 0", it, obsTimeout); end
      assertions++; if (obsWords.size() !== int'(count)) begin failures++; $display("[TB] FAIL rand%0d_word_count: got %0d expected %0d", it, obsWords.size(), count); end
      for (int i = 0; i < obsWords.size() && i < int'(count); i++) begin
        assertions++; if (obsWords[i] !== expWords[i]) begin failures++; $display("[TB] FAIL rand%0d_word%0d: got %h expected %h", it, i, obsWords[i], expWords[i]); end
`ifdef MEMP_STREAM_LAST_EN
        assertions++; if (obsLast[i] !== expLast[i]) begin failures++; $display("[TB] FAIL rand%0d_last%0d: got %b expected %b", it, i, obsLast[i], expLast[i]); end
`endif
      end
      assertions++; if (obsStableErr !== 0) begin failures++; $display("[TB] FAIL rand%0d_hold_stable: got %0d unstable cycles expected 0", it, obsStableErr); end
      assertions++; if (obsFinishAfter !== 1'b0 || obsBusyAfter !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_finish_close: got finish=%b busy=%b expected 0 0", it, obsFinishAfter, obsBusyAfter); end
    end
  endtask

  initial begin
    assertions   = 0;
    failures     = 0;
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    word_count   = '0;
    out_ready    = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_reset_mid_stream();
    test_restart_ignored();
    test_random_commands();
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/memp_vector_streamer.md
Name: memp_vector_streamer

Overview:
- Read-side sequencer for a memP-style wide vector memory (combinational read port, one word = no_of_units elements).
- On a start command it walks a contiguous address range and drives read_address.
- Each returned word is registered and presented on a valid/ready stream to the downstream arithmetic units.
- Pulses finish when the last word has been accepted.

Parameters:
- element_width, 32, bits per element
- no_of_units, 8, elements per memory word
- address_width, 20, width of memory address, base_address and word_count

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle command strobe, sampled only in IDLE
- base_address  input  address_width  first word address, latched on accepted start
- word_count  input  address_width  number of words to stream, latched on accepted start
- read_address  output  address_width  address to memory read port (registered)
- memory_output  input  no_of_units*element_width  combinational read data for read_address
- out_data  output  no_of_units*element_width  streamed word (registered)
- out_valid  output  1  out_data holds a word
- out_ready  input  1  downstream accepts the word this cycle
- busy  output  1  high from the cycle after an accepted start until finish
- finish  output  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high, clk): state=IDLE, read_address=0, out_data=0, out_valid=0, busy=0, finish=0, remaining=0.
- Reset mid-operation: stream is abandoned, all outputs return to reset values, no finish pulse is issued.
- States: IDLE, STREAM, DONE.
- IDLE, start=1, word_count!=0: latch read_address<=base_address and remaining<=word_count; go to STREAM; busy=1 next cycle.
- IDLE, start=1, word_count=0: go to DONE directly; no data is produced.
- start while not IDLE: ignored; latched parameters are unchanged.
- STREAM load condition: remaining!=0 && (!out_valid || out_ready). On load:
  - out_data<=memory_output
  - out_valid<=1
  - read_address<=read_address+1, wrapping modulo 2^address_width
  - remaining<=remaining-1
- STREAM, handshake (out_valid && out_ready) with no load: out_valid<=0.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- Throughput and latency:
  - Throughput is 1 word/cycle while out_ready is held high.
  - First out_valid occurs 2 cycles after the start edge, i.e. 1 cycle after busy rises.
- STREAM exit: when remaining=0 and (!out_valid || out_ready), the final word is consumed; go to DONE; out_valid<=0.
- DONE (one cycle): finish=1, busy<=0, then go to IDLE.
  - finish and busy deassert together on the following edge.
  - A start arriving in the same cycle as finish is ignored.
  - start is accepted from the next cycle onward.
- Memory coherence:
  - The word delivered is the memory value at the load cycle.
  - Writes to already-loaded addresses are not reflected.
  - Writes ahead of read_address are seen.
- finish is low in every cycle except the DONE cycle.

Optional Feature:
- Macro: MEMP_STREAM_LAST_EN.
- With the macro: adds output out_last (1 bit, reset 0).
  - out_last is loaded with the same timing as out_data.
  - out_last is high exactly while out_valid presents the final word of a command (the word loaded when remaining=1).
  - out_last is low otherwise.
- Without the macro: port out_last and its logic are absent; all other behaviour is identical.

Test Plan:
- mem[5..7]=A,B,C; start base=5, count=3, out_ready=1 → out_data A,B,C on 3 consecutive valid cycles; read_address 5,6,7,8; finish=1 in the cycle after the C handshake; busy falls with it.
- base=0, count=4, out_ready pattern 1,0,1,0,... → exactly 4 handshakes with mem[0..3] in order; no duplicates; out_data stable during every ready=0 cycle.
- start count=0 → out_valid never high; finish high one cycle after the start edge; busy stays 0.
- base=20'hFFFFE, count=4 → words from addresses FFFFE, FFFFF, 00000, 00001; read_address ends at 00002.
- Reset asserted after 2 of 5 words → next cycle out_valid=0, busy=0, finish=0, read_address=0; a new start base=10, count=1 then streams mem[10] with finish.
- start pulsed again during a count=3 stream → ignored, still 3 words; with MEMP_STREAM_LAST_EN, out_last=1 only on word 3.
